// File: rtl/pc_gen.sv
//------------------------------------------------------------------------------
// Module   : pc_gen
// Brief    : RV32I fetch PC generator with boot/run/halt control, fetch
//            valid/ready handshake, misaligned-redirect trapping and fetch count.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic             i_redirect,
  input  logic [XLEN-1:0]  i_redirect_pc,
  input  logic             i_trap,
  input  logic             i_halt,
  input  logic             i_resume,
  input  logic             i_fetch_ready,
  output logic [XLEN-1:0]  o_pc,
  output logic [XLEN-1:0]  o_pc_plus4,
  output logic             o_fetch_valid,
  output logic             o_misalign,
  output logic [XLEN-1:0]  o_misalign_addr,
  output logic [CNT_W-1:0] o_fetch_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  w_pc_nxt;
  logic [XLEN-1:0]  w_pc_plus4;
  logic [XLEN-1:0]  r_misalign_addr;
  logic             r_misalign;
  logic             w_misalign_nxt;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic             w_target_misaligned;
  logic             w_fetch_fire;

  assign w_pc_plus4          = r_pc + XLEN'(4);
  assign w_target_misaligned = |i_redirect_pc[1:0];
  assign w_fetch_fire        = (r_state == ST_RUN) && i_fetch_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_BOOT;
      r_pc            <= RESET_VECTOR;
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
      r_fetch_cnt     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_misalign <= w_misalign_nxt;
      if (w_misalign_nxt) begin
        r_misalign_addr <= i_redirect_pc;
      end
      if (w_fetch_fire) begin
        r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
      end
    end
  end

  // Next-PC priority is only evaluated in RUN; BOOT and HALT hold the PC
  // except that a trap also pulls HALT back into RUN.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_misalign_nxt = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_trap) begin
          w_pc_nxt = TRAP_VECTOR;
        end else if (i_redirect && !w_target_misaligned) begin
          w_pc_nxt = i_redirect_pc;
        end else if (i_redirect) begin
          w_pc_nxt       = TRAP_VECTOR;
          w_misalign_nxt = 1'b1;
        end else if (!i_stall && i_fetch_ready) begin
          w_pc_nxt = w_pc_plus4;
        end
        if (i_halt && !i_trap) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (i_trap) begin
          w_pc_nxt    = TRAP_VECTOR;
          w_state_nxt = ST_RUN;
        end else if (i_resume) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  assign o_pc            = r_pc;
  assign o_pc_plus4      = w_pc_plus4;
  assign o_fetch_valid   = (r_state == ST_RUN);
  assign o_misalign      = r_misalign;
  assign o_misalign_addr = r_misalign_addr;
  assign o_fetch_cnt     = r_fetch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
//------------------------------------------------------------------------------
// Module   : tb_pc_gen
// Brief    : Self-checking bench for pc_gen using an expected-result queue.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_gen;

  typedef struct packed {
    logic        trap;
    logic        redir;
    logic [31:0] rpc;
    logic        stall;
    logic        halt;
    logic        resume;
    logic        ready;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        fv;
    logic        mis;
    logic [31:0] maddr;
    logic [31:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall, redirect, trap, halt, resume, fetch_ready;
  logic [31:0] redirect_pc;
  logic [31:0] pc, pc_plus4, misalign_addr, fetch_cnt;
  logic        fetch_valid, misalign;

  int checks   = 0;
  int failures = 0;

  stim_t sq[$];
  exp_t  sb[$];

  pc_gen dut (
    .clk             (clk),
    .rst             (rst),
    .i_stall         (stall),
    .i_redirect      (redirect),
    .i_redirect_pc   (redirect_pc),
    .i_trap          (trap),
    .i_halt          (halt),
    .i_resume        (resume),
    .i_fetch_ready   (fetch_ready),
    .o_pc            (pc),
    .o_pc_plus4      (pc_plus4),
    .o_fetch_valid   (fetch_valid),
    .o_misalign      (misalign),
    .o_misalign_addr (misalign_addr),
    .o_fetch_cnt     (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic stim_t S(input logic t, input logic r, input logic [31:0] rp,
                              input logic st, input logic h, input logic rs, input logic rdy);
    return '{trap: t, redir: r, rpc: rp, stall: st, halt: h, resume: rs, ready: rdy};
  endfunction

  function automatic exp_t E(input logic [31:0] p, input logic v, input logic m,
                             input logic [31:0] ma, input logic [31:0] c);
    return '{pc: p, fv: v, mis: m, maddr: ma, cnt: c};
  endfunction

  task automatic drive(input stim_t s);
    trap        = s.trap;
    redirect    = s.redir;
    redirect_pc = s.rpc;
    stall       = s.stall;
    halt        = s.halt;
    resume      = s.resume;
    fetch_ready = s.ready;
  endtask

  function automatic exp_t observed();
    return {pc, fetch_valid, misalign, misalign_addr, fetch_cnt};
  endfunction

  // Leaves the DUT in RUN with pc = 0 and fetch_cnt = 0.
  task automatic do_reset();
    drive(S(0, 0, 0, 0, 0, 0, 1));
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t e, g;
    int   n;
    drive(S(0, 0, 0, 0, 0, 0, 1));
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    g = observed();
    if (g !== E(0, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL reset_state: got %h expected %h", g, E(0, 0, 0, 0, 0));
    end
    @(negedge clk) rst = 1'b0;
    #1;
    checks++;
    g = observed();
    if (g !== E(0, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL boot_state: got %h expected %h", g, E(0, 0, 0, 0, 0));
    end
    for (int i = 0; i < 3; i++) sq.push_back(S(0, 0, 0, 0, 0, 0, 1));
    sb.push_back(E(32'h0, 1, 0, 0, 0));
    sb.push_back(E(32'h4, 1, 0, 0, 1));
    sb.push_back(E(32'h8, 1, 0, 0, 2));
    n = 0;
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      @(posedge clk); #1;
      e = sb.pop_front();
      g = observed();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL boot_seq step %0d: got pc=%h fv=%b mis=%b maddr=%h cnt=%0d expected pc=%h fv=%b mis=%b maddr=%h cnt=%0d",
                 n, g.pc, g.fv, g.mis, g.maddr, g.cnt, e.pc, e.fv, e.mis, e.maddr, e.cnt);
      end
      n++;
    end
    checks++;
    if (pc_plus4 !== 32'hC) begin
      failures++;
      $display("FAIL pc_plus4: got %h expected %h", pc_plus4, 32'hC);
    end
  endtask

  task automatic test_priority();
    exp_t e, g;
    int   n;
    do_reset();
    sq.push_back(S(1, 1, 32'h40, 1, 0, 0, 1)); sb.push_back(E(32'h100, 1, 0, 0, 1));
    sq.push_back(S(0, 1, 32'h40, 0, 0, 0, 1)); sb.push_back(E(32'h40,  1, 0, 0, 2));
    sq.push_back(S(0, 0, 32'h0,  0, 0, 0, 1)); sb.push_back(E(32'h44,  1, 0, 0, 3));
    sq.push_back(S(1, 0, 32'h0,  0, 1, 0, 1)); sb.push_back(E(32'h100, 1, 0, 0, 4));
    sq.push_back(S(0, 0, 32'h0,  0, 0, 0, 1)); sb.push_back(E(32'h104, 1, 0, 0, 5));
    sq.push_back(S(0, 0, 32'h0,  1, 0, 0, 1)); sb.push_back(E(32'h104, 1, 0, 0, 6));
    sq.push_back(S(0, 1, 32'h80, 1, 0, 0, 0)); sb.push_back(E(32'h80,  1, 0, 0, 6));
    n = 0;
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      @(posedge clk); #1;
      e = sb.pop_front();
      g = observed();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL priority step %0d: got pc=%h fv=%b mis=%b maddr=%h cnt=%0d expected pc=%h fv=%b mis=%b maddr=%h cnt=%0d",
                 n, g.pc, g.fv, g.mis, g.maddr, g.cnt, e.pc, e.fv, e.mis, e.maddr, e.cnt);
      end
      n++;
    end
  endtask

  task automatic test_misalign();
    exp_t e, g;
    int   n;
    do_reset();
    sq.push_back(S(0, 1, 32'h42, 0, 0, 0, 1)); sb.push_back(E(32'h100, 1, 1, 32'h42, 1));
    sq.push_back(S(0, 0, 32'h0,  0, 0, 0, 1)); sb.push_back(E(32'h104, 1, 0, 32'h42, 2));
    sq.push_back(S(1, 1, 32'h43, 0, 0, 0, 1)); sb.push_back(E(32'h100, 1, 0, 32'h42, 3));
    sq.push_back(S(0, 1, 32'h7,  0, 0, 0, 1)); sb.push_back(E(32'h100, 1, 1, 32'h7,  4));
    sq.push_back(S(0, 0, 32'h0,  0, 0, 0, 1)); sb.push_back(E(32'h104, 1, 0, 32'h7,  5));
    n = 0;
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      @(posedge clk); #1;
      e = sb.pop_front();
      g = observed();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL misalign step %0d: got pc=%h fv=%b mis=%b maddr=%h cnt=%0d expected pc=%h fv=%b mis=%b maddr=%h cnt=%0d",
                 n, g.pc, g.fv, g.mis, g.maddr, g.cnt, e.pc, e.fv, e.mis, e.maddr, e.cnt);
      end
      n++;
    end
  endtask

  task automatic test_backpressure();
    exp_t e, g;
    int   n;
    do_reset();
    sq.push_back(S(0, 1, 32'h20, 0, 0, 0, 1)); sb.push_back(E(32'h20, 1, 0, 0, 1));
    for (int i = 0; i < 3; i++) begin
      sq.push_back(S(0, 0, 32'h0, 0, 0, 0, 0)); sb.push_back(E(32'h20, 1, 0, 0, 1));
    end
    sq.push_back(S(0, 0, 32'h0, 0, 0, 0, 1)); sb.push_back(E(32'h24, 1, 0, 0, 2));
    n = 0;
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      @(posedge clk); #1;
      e = sb.pop_front();
      g = observed();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL backpressure step %0d: got pc=%h fv=%b mis=%b maddr=%h cnt=%0d expected pc=%h fv=%b mis=%b maddr=%h cnt=%0d",
                 n, g.pc, g.fv, g.mis, g.maddr, g.cnt, e.pc, e.fv, e.mis, e.maddr, e.cnt);
      end
      n++;
    end
  endtask

  task automatic test_halt_wrap();
    exp_t e, g;
    int   n;
    do_reset();
    sq.push_back(S(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1)); sb.push_back(E(32'hFFFF_FFFC, 1, 0, 0, 1));
    sq.push_back(S(0, 0, 32'h0,  0, 0, 0, 1)); sb.push_back(E(32'h0,   1, 0, 0, 2));
    sq.push_back(S(0, 0, 32'h0,  0, 1, 0, 1)); sb.push_back(E(32'h4,   0, 0, 0, 3));
    sq.push_back(S(0, 1, 32'h42, 1, 0, 0, 1)); sb.push_back(E(32'h4,   0, 0, 0, 3));
    sq.push_back(S(0, 0, 32'h0,  0, 0, 0, 1)); sb.push_back(E(32'h4,   0, 0, 0, 3));
    sq.push_back(S(0, 0, 32'h0,  0, 1, 1, 1)); sb.push_back(E(32'h4,   1, 0, 0, 3));
    sq.push_back(S(0, 0, 32'h0,  0, 0, 0, 1)); sb.push_back(E(32'h8,   1, 0, 0, 4));
    sq.push_back(S(0, 0, 32'h0,  0, 1, 0, 1)); sb.push_back(E(32'hC,   0, 0, 0, 5));
    sq.push_back(S(1, 0, 32'h0,  0, 0, 0, 1)); sb.push_back(E(32'h100, 1, 0, 0, 5));
    sq.push_back(S(0, 0, 32'h0,  0, 0, 0, 1)); sb.push_back(E(32'h104, 1, 0, 0, 6));
    n = 0;
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      @(posedge clk); #1;
      e = sb.pop_front();
      g = observed();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL halt_wrap step %0d: got pc=%h fv=%b mis=%b maddr=%h cnt=%0d expected pc=%h fv=%b mis=%b maddr=%h cnt=%0d",
                 n, g.pc, g.fv, g.mis, g.maddr, g.cnt, e.pc, e.fv, e.mis, e.maddr, e.cnt);
      end
      n++;
    end
  endtask

  task automatic test_async_reset();
    exp_t e, g;
    int   n;
    do_reset();
    sq.push_back(S(0, 0, 32'h0, 0, 0, 0, 1)); sb.push_back(E(32'h4, 1, 0, 0, 1));
    sq.push_back(S(0, 0, 32'h0, 0, 0, 0, 1)); sb.push_back(E(32'h8, 1, 0, 0, 2));
    n = 0;
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      @(posedge clk); #1;
      e = sb.pop_front();
      g = observed();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL async_pre step %0d: got pc=%h fv=%b cnt=%0d expected pc=%h fv=%b cnt=%0d",
                 n, g.pc, g.fv, g.cnt, e.pc, e.fv, e.cnt);
      end
      n++;
    end
    // Pending redirect is cut off by a reset between clock edges.
    drive(S(0, 1, 32'h80, 0, 0, 0, 1));
    #2 rst = 1'b1;
    #1;
    e = E(32'h0, 0, 0, 0, 0);
    g = observed();
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL async_immediate: got pc=%h fv=%b cnt=%0d expected pc=%h fv=%b cnt=%0d",
               g.pc, g.fv, g.cnt, e.pc, e.fv, e.cnt);
    end
    // Redirect and trap held into BOOT must be ignored there.
    drive(S(1, 1, 32'h80, 0, 0, 0, 1));
    @(negedge clk) rst = 1'b0;
    sb.push_back(E(32'h0, 1, 0, 0, 0));
    @(posedge clk); #1;
    e = sb.pop_front();
    g = observed();
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL async_boot_ignore: got pc=%h fv=%b cnt=%0d expected pc=%h fv=%b cnt=%0d",
               g.pc, g.fv, g.cnt, e.pc, e.fv, e.cnt);
    end
    drive(S(0, 0, 32'h0, 0, 0, 0, 1));
    sb.push_back(E(32'h4, 1, 0, 0, 1));
    @(posedge clk); #1;
    e = sb.pop_front();
    g = observed();
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL async_resume_seq: got pc=%h fv=%b cnt=%0d expected pc=%h fv=%b cnt=%0d",
               g.pc, g.fv, g.cnt, e.pc, e.fv, e.cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(S(0, 0, 0, 0, 0, 0, 1));
    test_reset();
    test_priority();
    test_misalign();
    test_backpressure();
    test_halt_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
